// File: rtl/ioctl_mem_loader_if.sv
// HPS download stream and memory write port bundled for the loader.
// The slave modport is the loader's view; the master modport is the HPS/memory side.
interface ioctl_mem_loader_if #(
    parameter int unsigned AW = 16
);
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [26:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          mem_ack;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        input  ioctl_wait, mem_addr, mem_din, mem_we
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        output ioctl_wait, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/ioctl_mem_loader.sv
// Loads the HPS download stream into core memory through a small FIFO and a req/ack writer,
// relocating each download by menu index and reporting length, overflow and completion.
module ioctl_mem_loader #(
    parameter int unsigned   AW         = 16,
    parameter int unsigned   FIFO_DEPTH = 4,
    parameter logic [7:0]    ROM_INDEX  = 8'h00,
    parameter logic [7:0]    CART_INDEX = 8'h01,
    parameter logic [AW-1:0] ROM_BASE   = 16'h8000,
    parameter int unsigned   ROM_SIZE   = 32'h4000,
    parameter logic [AW-1:0] CART_BASE  = 16'hC000,
    parameter int unsigned   CART_SIZE  = 32'h4000
) (
    input  logic              clk_sys,
    input  logic              reset,
    ioctl_mem_loader_if.slave bus,
    output logic              load_busy,
    output logic              load_done,
    output logic [AW:0]       load_len,
    output logic              load_overflow,
    output logic              cart_loaded
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = AW + 8;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;
    typedef enum logic {W_IDLE, W_REQ} wstate_t;

    state_t        state_q, state_d;
    wstate_t       wstate_q, wstate_d;
    logic          dl_q;
    logic [7:0]    idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic          ovf_q, ovf_d;
    logic          cart_q, cart_d;
    logic          wait_q, wait_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] fifo_q [FIFO_DEPTH];

    logic          rise, fall, known, in_win, full, wr_acc, push, pop, mem_we;
    logic [AW-1:0] base;
    logic [AW:0]   addr_len;
    logic [EW-1:0] push_entry, head;

    assign rise = bus.ioctl_download & ~dl_q;
    assign fall = ~bus.ioctl_download & dl_q;

    always_comb begin
        known  = 1'b0;
        base   = '0;
        in_win = 1'b0;
        if (idx_q == ROM_INDEX) begin
            known  = 1'b1;
            base   = ROM_BASE;
            in_win = 32'(bus.ioctl_addr) < ROM_SIZE;
        end else if (idx_q == CART_INDEX) begin
            known  = 1'b1;
            base   = CART_BASE;
            in_win = 32'(bus.ioctl_addr) < CART_SIZE;
        end
    end

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign wr_acc     = (state_q == S_ACTIVE) && bus.ioctl_wr;
    assign push       = wr_acc && known && in_win && !full;
    assign pop        = (wstate_q == W_REQ) && bus.mem_ack;
    assign addr_len   = (AW+1)'(bus.ioctl_addr[AW-1:0]) + (AW+1)'(1);
    assign push_entry = {base + bus.ioctl_addr[AW-1:0], bus.ioctl_dout};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        cart_d  = cart_q;
        case (state_q)
            S_IDLE:   if (rise) state_d = S_ACTIVE;
            S_ACTIVE: if (fall) state_d = S_DRAIN;
            S_DRAIN: begin
                if (rise) state_d = S_ACTIVE;
                else if (count_q == '0 && wstate_q == W_IDLE) state_d = S_DONE;
            end
            S_DONE: begin
                if (idx_q == CART_INDEX) cart_d = 1'b1;
                state_d = rise ? S_ACTIVE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Entry to ACTIVE never coincides with an accepted byte, so the clears cannot collide.
        if (state_d == S_ACTIVE && state_q != S_ACTIVE) begin
            idx_d = bus.ioctl_index;
            len_d = '0;
            ovf_d = 1'b0;
        end
        if (wr_acc) begin
            if (push) begin
                if (addr_len > len_q) len_d = addr_len;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  if (count_q != '0) wstate_d = W_REQ;
            W_REQ:   if (bus.mem_ack) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        wait_d   = (count_d >= CW'(FIFO_DEPTH - 1));
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wstate_q <= W_IDLE;
            dl_q     <= 1'b0;
            idx_q    <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
            cart_q   <= 1'b0;
            wait_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wstate_q <= wstate_d;
            dl_q     <= bus.ioctl_download;
            idx_q    <= idx_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            cart_q   <= cart_d;
            wait_q   <= wait_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) fifo_q[wr_ptr_q] <= push_entry;
    end

    // Storage is not reset, so the write port is forced to zero whenever no request is open.
    assign head           = fifo_q[rd_ptr_q];
    assign mem_we         = (wstate_q == W_REQ);
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_we ? head[EW-1:8] : '0;
    assign bus.mem_din    = mem_we ? head[7:0] : '0;
    assign bus.ioctl_wait = wait_q;

    assign load_busy     = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    assign load_done     = (state_q == S_DONE);
    assign load_len      = len_q;
    assign load_overflow = ovf_q;
    assign cart_loaded   = cart_q;
endmodule

// File: tb/tb_ioctl_mem_loader.sv
// Randomized bench for ioctl_mem_loader: a transaction-level model predicts the memory write
// sequence, FIFO occupancy, load length, overflow and completion pulses.
module tb_ioctl_mem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_busy, load_done, load_overflow, cart_loaded;
    logic [16:0] load_len;

    ioctl_mem_loader_if #(.AW(16)) bus ();

    ioctl_mem_loader #(.AW(16), .FIFO_DEPTH(4)) dut (
        .clk_sys       (clk),
        .reset         (rst),
        .bus           (bus),
        .load_busy     (load_busy),
        .load_done     (load_done),
        .load_len      (load_len),
        .load_overflow (load_overflow),
        .cart_loaded   (cart_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0, bad = 0;
    int          pushes = 0, acks = 0, done_cnt = 0, done_tgt = 0;
    bit          chk_en = 0, stall = 0, ack_rand = 0, wait_hi_seen = 0, prev_w = 0;
    logic [16:0] len_exp = '0;
    bit          ovf_exp = 0, cart_exp = 0;
    logic [7:0]  cur_idx = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic tick;
        prev_w = bus.ioctl_wait;
        @(negedge clk);
    endtask

    // Memory-side responder and per-cycle comparison against the model.
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                chk("wait", 32'(bus.ioctl_wait), 32'((pushes - acks) >= 3));
                if (bus.ioctl_wait) wait_hi_seen = 1;
                if (bus.mem_we) begin
                    if (exp_q.size() == 0) begin
                        fail_now("spurious_we");
                        bus.mem_ack = 1'b0;
                    end else begin
                        chk("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0].a));
                        chk("mem_din", 32'(bus.mem_din), 32'(exp_q[0].d));
                        if (!stall && (!ack_rand || $urandom_range(0, 3) != 0)) begin
                            bus.mem_ack = 1'b1;
                            void'(exp_q.pop_front());
                            acks++;
                        end else begin
                            bus.mem_ack = 1'b0;
                        end
                    end
                end else begin
                    bus.mem_ack = 1'b0;
                end
                if (load_done) begin
                    done_cnt++;
                    chk("done_after_last_write", 32'(exp_q.size()), 32'd0);
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
        end
    end

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        cur_idx = idx;
        len_exp = '0;
        ovf_exp = 0;
        tick();
        tick();
        chk("busy_start", 32'(load_busy), 32'd1);
    endtask

    task automatic send_byte(input logic [26:0] addr, input logic [7:0] data);
        int guard = 0;
        while (prev_w && guard < 200) begin
            bus.ioctl_wr = 1'b0;
            tick();
            guard++;
        end
        if (guard >= 200) fail_now("wait_release");
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = addr;
        bus.ioctl_dout = data;
        if ((cur_idx == 8'h00 || cur_idx == 8'h01) && addr < 27'h4000) begin
            exp_q.push_back('{a: (cur_idx == 8'h00 ? 16'h8000 : 16'hC000) + addr[15:0], d: data});
            pushes++;
            if (17'(addr) + 17'd1 > len_exp) len_exp = 17'(addr) + 17'd1;
        end else begin
            ovf_exp = 1;
        end
        tick();
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic finish_dl;
        int n = 0;
        bus.ioctl_download = 1'b0;
        done_tgt++;
        while (done_cnt < done_tgt && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) fail_now("done_timeout");
        repeat (3) tick();
        if (cur_idx == 8'h01) cart_exp = 1;
        chk("done_once", 32'(done_cnt), 32'(done_tgt));
        chk("load_len", 32'(load_len), 32'(len_exp));
        chk("overflow", 32'(load_overflow), 32'(ovf_exp));
        chk("cart_loaded", 32'(cart_loaded), 32'(cart_exp));
        chk("busy_end", 32'(load_busy), 32'd0);
        chk("all_written", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(load_busy), 32'd0);
        chk({tag, "_done"}, 32'(load_done), 32'd0);
        chk({tag, "_len"}, 32'(load_len), 32'd0);
        chk({tag, "_ovf"}, 32'(load_overflow), 32'd0);
        chk({tag, "_cart"}, 32'(cart_loaded), 32'd0);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_wait"}, 32'(bus.ioctl_wait), 32'd0);
        chk({tag, "_maddr"}, 32'(bus.mem_addr), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int a0, d0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = '0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick();
        chk_all_zero("reset");
        chk_en = 1;

        // ROM load, immediate ack
        ack_rand = 0;
        a0 = acks;
        start_dl(8'h00);
        for (int i = 0; i < 16; i++) send_byte(27'(i), 8'(i));
        finish_dl();
        chk("rom_len_lit", 32'(load_len), 32'd16);
        chk("rom_writes", 32'(acks - a0), 32'd16);
        chk("rom_cart_lit", 32'(cart_loaded), 32'd0);

        // Cart load at top of window, with push-to-request latency
        start_dl(8'h01);
        send_byte(27'h3FFF, 8'hA5);
        chk("lat_cycle1_we", 32'(bus.mem_we), 32'd0);
        tick();
        chk("lat_cycle2_we", 32'(bus.mem_we), 32'd1);
        chk("cart_addr_lit", 32'(bus.mem_addr), 32'hFFFF);
        chk("cart_din_lit", 32'(bus.mem_din), 32'hA5);
        finish_dl();
        chk("cart_len_lit", 32'(load_len), 32'h4000);
        chk("cart_loaded_lit", 32'(cart_loaded), 32'd1);

        // Back-pressure: acks withheld 20 cycles while the HPS streams with one cycle of lag
        start_dl(8'h00);
        wait_hi_seen = 0;
        stall = 1;
        fork
            begin
                repeat (20) @(negedge clk);
                stall = 0;
            end
        join_none
        for (int i = 0; i < 12; i++) send_byte(27'(16'h100 + i), 8'($urandom));
        finish_dl();
        chk("wait_seen", 32'(wait_hi_seen), 32'd1);

        // Drops: out of window, unknown index
        start_dl(8'h00);
        send_byte(27'h4000, 8'h11);
        finish_dl();
        chk("drop_ovf_lit", 32'(load_overflow), 32'd1);
        start_dl(8'h07);
        send_byte(27'h0, 8'h22);
        finish_dl();
        chk("badidx_ovf_lit", 32'(load_overflow), 32'd1);

        // Randomized downloads
        ack_rand = 1;
        for (int k = 0; k < 6; k++) begin
            int sel;
            sel = $urandom_range(0, 3);
            start_dl(sel == 3 ? 8'h07 : (sel == 2 ? 8'h01 : 8'h00));
            for (int i = 0; i < 20; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send_byte(27'($urandom_range(0, 32'h4400)), 8'($urandom));
            end
            finish_dl();
        end

        // Re-assert during drain with 3 bytes queued
        ack_rand = 0;
        stall = 1;
        start_dl(8'h00);
        for (int i = 0; i < 3; i++) send_byte(27'(8'h10 + i), 8'(8'hB0 + i));
        bus.ioctl_download = 1'b0;
        tick();
        tick();
        chk("drain_busy", 32'(load_busy), 32'd1);
        bus.ioctl_download = 1'b1;
        len_exp = '0;
        ovf_exp = 0;
        tick();
        tick();
        chk("reassert_len_clear", 32'(load_len), 32'd0);
        chk("queued_bytes", 32'(exp_q.size()), 32'd3);
        d0 = done_cnt;
        stall = 0;
        repeat (20) tick();
        chk("queued_written", 32'(exp_q.size()), 32'd0);
        chk("no_done_superseded", 32'(done_cnt), 32'(d0));
        send_byte(27'h20, 8'hC0);
        send_byte(27'h21, 8'hC1);
        finish_dl();
        chk("reassert_one_done", 32'(done_cnt - d0), 32'd1);
        chk("reassert_len_lit", 32'(load_len), 32'h22);

        // Reset while a write request is open
        stall = 1;
        start_dl(8'h00);
        send_byte(27'h5, 8'h77);
        repeat (3) tick();
        chk("we_before_reset", 32'(bus.mem_we), 32'd1);
        chk_en = 0;
        rst = 1'b1;
        #1;
        chk("we_on_reset", 32'(bus.mem_we), 32'd0);
        bus.ioctl_download = 1'b0;
        exp_q.delete();
        pushes = 0;
        acks = 0;
        stall = 0;
        cart_exp = 0;
        tick();
        rst = 1'b0;
        tick();
        chk_en = 1;
        d0 = done_cnt;
        repeat (10) tick();
        chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
        chk_all_zero("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
